// File: rtl/wb_regfile.sv
// wb_regfile: integer register file at the consumer end of the MEM/WB writeback.
//   32 x 64-bit registers. Index ZERO_REG (X31) has no storage, always reads 0
//   and ignores writes. Two combinational read ports serve the ID stage. A value
//   being written back in the current cycle bypasses straight to the read ports.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset; clears storage and forces reads to 0
//   RegWrite  write enable from MEM/WB
//   Rd, Dw    write index / write data from MEM/WB
//   Ra, Rb    read indices (ID stage)
//   Da, Db    read data

// D_FF_En_VAR: WIDTH-bit register with synchronous enable and async active-low clear.
//   clk, reset (active-low async), en, d -> q
module D_FF_En_VAR #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

module wb_regfile #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] Rd,
  input  logic [DATA_W-1:0] Dw,
  input  logic [ADDR_W-1:0] Ra,
  input  logic [ADDR_W-1:0] Rb,
  output logic [DATA_W-1:0] Da,
  output logic [DATA_W-1:0] Db
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [NUM_REGS];

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_reg
      if (g == ZERO_REG) begin : g_zero
        assign regs[g] = '0;
      end else begin : g_store
        logic we;
        assign we = RegWrite && (Rd == ADDR_W'(g));
        D_FF_En_VAR #(.WIDTH(DATA_W)) u_ff (
          .clk   (clk),
          .reset (reset),
          .en    (we),
          .d     (Dw),
          .q     (regs[g])
        );
      end
    end
  endgenerate

  // Zero-register check outranks bypass; reset gates the whole read path,
  // bypass included, so nothing nonzero escapes while reset is held.
  always_comb begin
    Da = '0;
    if (reset && (Ra != ZERO_IDX)) begin
      if (RegWrite && (Rd == Ra)) begin
        Da = Dw;
      end else begin
        Da = regs[Ra];
      end
    end
  end

  always_comb begin
    Db = '0;
    if (reset && (Rb != ZERO_IDX)) begin
      if (RegWrite && (Rd == Rb)) begin
        Db = Dw;
      end else begin
        Db = regs[Rb];
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile.
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  Rd;
  logic [63:0] Dw;
  logic [4:0]  Ra;
  logic [4:0]  Rb;
  logic [63:0] Da;
  logic [63:0] Db;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  localparam logic [63:0] STEP = 64'h0101_0101_0101_0101;

  wb_regfile #(
    .DATA_W   (64),
    .ADDR_W   (5),
    .NUM_REGS (32),
    .ZERO_REG (31)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .RegWrite (RegWrite),
    .Rd       (Rd),
    .Dw       (Dw),
    .Ra       (Ra),
    .Rb       (Rb),
    .Da       (Da),
    .Db       (Db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a write in the low phase, commit on the rising edge, drop RegWrite just after.
  task automatic wr(input logic [4:0] r, input logic [63:0] d);
    @(negedge clk);
    RegWrite = 1'b1;
    Rd = r;
    Dw = d;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
  endtask

  initial begin
    reset = 1'b0; RegWrite = 1'b0; Rd = '0; Dw = '0; Ra = 5'd5; Rb = 5'd5;
    #12;
    check("reset_da", Da, 64'h0);
    check("reset_db", Db, 64'h0);

    // Bypass must be gated by reset.
    RegWrite = 1'b1; Rd = 5'd5; Dw = 64'hAAAA; #1;
    check("reset_bypass_da", Da, 64'h0);
    check("reset_bypass_db", Db, 64'h0);
    // Unknown write enable during reset must not corrupt storage.
    RegWrite = 1'bx;
    @(posedge clk); #1;
    RegWrite = 1'b0;
    @(negedge clk);
    reset = 1'b1; #1;
    check("reset_x_we_da", Da, 64'h0);

    // Reset clear mid-cycle.
    wr(5'd5, 64'hDEAD_BEEF_0000_0001);
    Ra = 5'd5; #1;
    check("x5_written", Da, 64'hDEAD_BEEF_0000_0001);
    reset = 1'b0; #1;
    check("reset_async_clear", Da, 64'h0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("after_release", Da, 64'h0);

    // Basic write/read.
    wr(5'd1, 64'h0123_4567_89AB_CDEF);
    wr(5'd30, 64'hFFFF_FFFF_FFFF_FFFF);
    Ra = 5'd1; Rb = 5'd30; #1;
    check("basic_da_x1", Da, 64'h0123_4567_89AB_CDEF);
    check("basic_db_x30", Db, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 32; i++) begin
      if (i != 1 && i != 30) begin
        Ra = 5'(i); Rb = 5'(i); #1;
        check($sformatf("others_zero_da_%0d", i), Da, 64'h0);
        check($sformatf("others_zero_db_%0d", i), Db, 64'h0);
      end
    end

    // Zero register write: no bypass, no storage.
    @(negedge clk);
    RegWrite = 1'b1; Rd = 5'd31; Dw = 64'h55; Ra = 5'd31; Rb = 5'd31;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("zero_da_c%0d", c), Da, 64'h0);
      check($sformatf("zero_db_c%0d", c), Db, 64'h0);
      @(negedge clk);
    end
    RegWrite = 1'b0; Ra = 5'd1; Rb = 5'd30; #1;
    check("zero_no_side_x1", Da, 64'h0123_4567_89AB_CDEF);
    check("zero_no_side_x30", Db, 64'hFFFF_FFFF_FFFF_FFFF);

    // Bypass.
    wr(5'd7, 64'h10);
    @(negedge clk);
    Ra = 5'd7; Rb = 5'd7; #1;
    check("bypass_pre_da", Da, 64'h10);
    RegWrite = 1'b1; Rd = 5'd7; Dw = 64'h20; #1;
    check("bypass_da", Da, 64'h20);
    check("bypass_db", Db, 64'h20);
    Rb = 5'd1; #1;
    check("bypass_one_port_da", Da, 64'h20);
    check("bypass_other_port_db", Db, 64'h0123_4567_89AB_CDEF);
    Rb = 5'd7;
    @(posedge clk); #1;
    RegWrite = 1'b0; Dw = 64'h0; #1;
    check("bypass_stored_da", Da, 64'h20);
    check("bypass_stored_db", Db, 64'h20);

    // Write disable.
    @(negedge clk);
    RegWrite = 1'b0; Rd = 5'd3; Dw = 64'h99; Ra = 5'd3;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("wdis_da_c%0d", c), Da, 64'h0);
    end

    // Sweep.
    for (int i = 0; i < 31; i++) begin
      wr(5'(i), STEP * 64'(i));
    end
    for (int i = 0; i < 31; i++) begin
      Ra = 5'(i); Rb = 5'(30 - i); #1;
      check($sformatf("sweep_da_%0d", i), Da, STEP * 64'(i));
      check($sformatf("sweep_db_%0d", 30 - i), Db, STEP * 64'(30 - i));
    end
    Ra = 5'd31; Rb = 5'd31; #1;
    check("sweep_x31_da", Da, 64'h0);
    check("sweep_x31_db", Db, 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB writeback interface: the integer register file that receives {Rd, Dw, RegWrite} from the MEM/WB pipeline register.
- Serves two combinational read ports to the ID stage.
- 32 x 64-bit registers; X31 is the hardwired zero register.
- Same-cycle read-after-write bypass, so a value being written back is visible to a decode in that same cycle without a stall.

Parameters:
- DATA_W, 64, register width in bits
- ADDR_W, 5, register index width
- NUM_REGS, 32, number of architectural registers (2**ADDR_W)
- ZERO_REG, 31, index that always reads 0 and ignores writes

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- RegWrite  input  1  write enable from MEM/WB control_out
- Rd  input  ADDR_W  write register index from MEM/WB Rd_out
- Dw  input  DATA_W  write data from MEM/WB Dw_out
- Ra  input  ADDR_W  read port A index (ID stage)
- Rb  input  ADDR_W  read port B index (ID stage)
- Da  output  DATA_W  read port A data
- Db  output  DATA_W  read port B data

Behaviour:
- Storage: NUM_REGS-1 registers of DATA_W flops (indices 0..30). X31 has no storage.
- Reset:
  - reset=0 clears all stored registers to 0 immediately, independent of clk.
  - Writes are blocked while reset=0.
  - Da and Db read 0 for every index during reset, including the bypass path: bypass is gated by reset.
  - Release is synchronous-safe: the first write can occur on the first rising edge with reset=1.
- Write:
  - On a rising clk edge with reset=1, RegWrite=1 and Rd!=ZERO_REG, register[Rd] <= Dw.
  - All other registers hold.
  - RegWrite=1 with Rd=ZERO_REG is a no-op.
  - RegWrite=0: no state change, regardless of Rd and Dw.
- Read (combinational, zero latency):
  - If Ra==ZERO_REG, Da=0.
  - Else if RegWrite=1 and Rd==Ra, Da=Dw (bypass).
  - Else Da=register[Ra].
  - Port B is identical using Rb/Db.
- Bypass priority: the zero-register check takes precedence over bypass. Writing X31 never makes Da/Db nonzero.
- Simultaneous reads: Ra==Rb is legal, and both ports return the same value.
- Both read ports may bypass the same write in the same cycle.
- Write-then-read across cycles: a value written at edge N appears from storage on Da/Db immediately after edge N, with no extra latency.
- Indices are fully decoded; there are no out-of-range indices at the default parameters.
- X/unknown on RegWrite must not corrupt storage when reset=0. When reset=1, verification treats it as illegal stimulus.
- Implementation: built from the team's D_FF_En_VAR (per-register enable = decoded Rd & RegWrite) plus read muxes. There is no behavioural memory array.

Test Plan:
- Reset clear: write 0xDEAD_BEEF_0000_0001 to X5, then assert reset=0 mid-cycle (between edges) -> Da (Ra=5) reads 0 immediately. After release with no writes, Da still reads 0.
- Basic write/read: write X1=0x0123_4567_89AB_CDEF and X30=0xFFFF_FFFF_FFFF_FFFF on consecutive edges, then Ra=1, Rb=30 -> Da=0x0123_4567_89AB_CDEF, Db=0xFFFF_FFFF_FFFF_FFFF. All other registers read 0.
- Zero register: RegWrite=1, Rd=31, Dw=0x55 for 3 cycles with Ra=Rb=31 -> Da=Db=0 every cycle, including during the write cycle (no bypass). No other register changes.
- Bypass: X7 holds 0x10. Drive RegWrite=1, Rd=7, Dw=0x20 with Ra=7, Rb=7 before the edge -> Da=Db=0x20 in that cycle. After the edge with RegWrite=0 -> Da=Db=0x20 from storage.
- Write disable: RegWrite=0, Rd=3, Dw=0x99 for 4 edges -> X3 remains at its prior value (0), Da(Ra=3)=0 throughout.
- Sweep: write X(i)=i*0x0101_0101_0101_0101 for i=0..30, then read every pair (Ra=i, Rb=30-i) -> each port returns its programmed value. Read of 31 returns 0.
